// File: rtl/mioc_pat_seq.sv
// mioc_pat_seq: on-chip pattern sequencer for MIOC register characterisation.
// Stores stim/exp vectors, drives each stim onto the register-under-test
// input lanes for HOLD cycles, samples the outputs on the last hold cycle and
// compares them against the expected value, keeping a saturating error count.
//
// Optional build macro MIOC_PATSEQ_MASK_EN: when defined, a per-vector mask is
// stored alongside exp and masked output lanes are treated as don't-care.
// When undefined the mask bits of load_data are dropped and never stored.
//
// Timeline for a run started at cycle 0 with n vectors:
//   vector k is driven in cycles 1+k*HOLD .. (k+1)*HOLD,
//   its capture pulse appears in cycle (k+1)*HOLD+1,
//   done rises in cycle n*HOLD+1 together with the last capture pulse.
//
// Capture handshake: cap_valid is a valid-only, one-cycle pulse with no ready
// back-pressure; cap_idx and cap_data are meaningful only while cap_valid=1
// and the consumer must take them in that cycle.
module mioc_pat_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int DEPTH = 16,
    parameter int HOLD  = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_we,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [IN_W+2*OUT_W-1:0]    load_data,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic                       start,
    input  logic [OUT_W-1:0]           obs,
    output logic [IN_W-1:0]            drv,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CNT_W-1:0]           err_count,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx,
    output logic                       cap_valid,
    output logic [$clog2(DEPTH)-1:0]   cap_idx,
    output logic [OUT_W-1:0]           cap_data,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD);
`ifdef MIOC_PATSEQ_MASK_EN
    localparam int MW = IN_W + 2 * OUT_W;
`else
    localparam int MW = IN_W + OUT_W;
`endif

    localparam logic [AW:0]      N_MAX     = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
    localparam logic [CNT_W-1:0] ERR_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Pattern memory; contents survive reset
    logic [MW-1:0] mem_q [DEPTH];

    // Run control and result registers
    logic [AW:0]        n_q, n_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [AW-1:0]      first_q, first_d;
    logic               pass_q, pass_d;
    logic               cap_valid_q, cap_valid_d;
    logic [AW-1:0]      cap_idx_q, cap_idx_d;
    logic [OUT_W-1:0]   cap_data_q, cap_data_d;

    // Decoded fields of the entry currently being applied
    logic [MW-1:0]      entry;
    logic [IN_W-1:0]    stim_cur;
    logic [OUT_W-1:0]   exp_cur;
    logic [OUT_W-1:0]   mask_cur;

    logic               idle_like;
    logic               running;
    logic               go;
    logic [AW:0]        n_start;
    logic               hold_last;
    logic               vec_last;
    logic               sample;
    logic               mismatch;

    assign entry    = mem_q[idx_q];
    assign stim_cur = entry[IN_W-1:0];
    assign exp_cur  = entry[IN_W +: OUT_W];

`ifdef MIOC_PATSEQ_MASK_EN
    assign mask_cur = entry[IN_W+OUT_W +: OUT_W];
`else
    // Mask lanes of load_data are not stored in this build
    logic unused_mask_bits;
    assign unused_mask_bits = ^load_data[IN_W+2*OUT_W-1:IN_W+OUT_W];
    assign mask_cur = '0;
`endif

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign running   = (state_q == S_APPLY) || (state_q == S_CHECK);
    assign go        = idle_like && start;

    // Clamp the requested vector count to the memory depth
    assign n_start   = (num_vec > N_MAX) ? N_MAX : num_vec;

    assign hold_last = (hold_q == HOLD_LAST);
    assign vec_last  = ({1'b0, idx_q} == (n_q - (AW + 1)'(1)));

    // The sample edge closes the last hold cycle of the current vector.
    // CHECK always sits at hold count 0, so sampling can only happen in APPLY.
    assign sample    = (state_q == S_APPLY) && hold_last;
    assign mismatch  = |((obs ^ exp_cur) & ~mask_cur);

    // Pattern memory write port, ignored while a run is in progress
    always_ff @(posedge clk) begin
        if (load_we && idle_like) begin
            mem_q[load_addr] <= load_data[MW-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (n_start == '0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: begin
                if (hold_last) begin
                    state_d = vec_last ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                // CHECK overlaps the first hold cycle of the next vector
                state_d = S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = running;
        done      = (state_q == S_DONE);
        drv       = running ? stim_cur : '0;
        dbg_state = state_q;
    end

    // Datapath next-state: run setup, hold counting, compare and capture
    always_comb begin
        n_d         = n_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        err_d       = err_q;
        first_d     = first_q;
        pass_d      = pass_q;
        cap_valid_d = 1'b0;
        cap_idx_d   = cap_idx_q;
        cap_data_d  = cap_data_q;

        if (go) begin
            n_d     = n_start;
            idx_d   = '0;
            hold_d  = '0;
            err_d   = '0;
            first_d = '0;
            // An empty run completes immediately with a clean result
            pass_d  = (n_start == '0);
        end else if (running) begin
            hold_d = hold_last ? '0 : hold_q + HW'(1);
            if (sample) begin
                cap_valid_d = 1'b1;
                cap_idx_d   = idx_q;
                cap_data_d  = obs;
                if (mismatch) begin
                    if (err_q == '0) begin
                        first_d = idx_q;
                    end
                    if (err_q != ERR_SAT) begin
                        err_d = err_q + CNT_W'(1);
                    end
                end
                if (vec_last) begin
                    // Final verdict includes the compare of this last vector
                    pass_d = (err_q == '0) && !mismatch;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
        end
    end

    // Datapath registers; a mid-run reset abandons the run at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q         <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            err_q       <= '0;
            first_q     <= '0;
            pass_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_data_q  <= '0;
        end else begin
            n_q         <= n_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            first_q     <= first_d;
            pass_q      <= pass_d;
            cap_valid_q <= cap_valid_d;
            cap_idx_q   <= cap_idx_d;
            cap_data_q  <= cap_data_d;
        end
    end

    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign cap_valid     = cap_valid_q;
    assign cap_idx       = cap_idx_q;
    assign cap_data      = cap_data_q;

endmodule

// File: tb/tb_mioc_pat_seq.sv
// tb_mioc_pat_seq: randomized bench for mioc_pat_seq with a cycle-level
// reference model. The DUT outputs are looped back (obs = low drv lanes ^ flip).
`timescale 1ns/1ps
module tb_mioc_pat_seq;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int DEPTH = 8;
    localparam int HOLD  = 4;
    localparam int CNT_W = 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = IN_W + 2 * OUT_W;
    localparam int CAPW  = 32 + AW + OUT_W;
    localparam int RESW  = 32 + CNT_W + AW + 1;
    localparam int INF   = 32'h7fff_ffff;
    localparam int BUDGET = DEPTH * HOLD + 8;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_we = 1'b0;
    logic [AW-1:0]     load_addr = '0;
    logic [DW-1:0]     load_data = '0;
    logic [AW:0]       num_vec = '0;
    logic              start = 1'b0;
    logic [OUT_W-1:0]  flip = '0;
    logic [OUT_W-1:0]  obs;
    logic [IN_W-1:0]   drv;
    logic              busy, done, pass, cap_valid;
    logic [CNT_W-1:0]  err_count;
    logic [AW-1:0]     first_err_idx, cap_idx;
    logic [OUT_W-1:0]  cap_data;
    logic [1:0]        dbg_state;

    assign obs = drv[OUT_W-1:0] ^ flip;

    mioc_pat_seq #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .num_vec(num_vec), .start(start), .obs(obs),
        .drv(drv), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .cap_valid(cap_valid), .cap_idx(cap_idx),
        .cap_data(cap_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [DW-1:0]   mem_m [DEPTH];
    logic [CAPW-1:0] cap_q [$];
    logic [RESW-1:0] res_q [$];
    int run_s = 0, run_n = 0, run_end = INF;
    bit run_live = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle c is inside the drive window of the current run
    function automatic bit exp_busy_at(input int c);
        return run_live && (c >= run_s + 1) && (c <= run_s + run_n * HOLD) && (c <= run_end);
    endfunction

    function automatic logic [IN_W-1:0] exp_drv_at(input int c);
        int k;
        logic [DW-1:0] e;
        if (!exp_busy_at(c)) return '0;
        k = (c - run_s - 1) / HOLD;
        e = mem_m[k];
        return e[IN_W-1:0];
    endfunction

    // Reference model of one run started in cycle s
    task automatic model_run(input int s, input int nv, input logic [OUT_W-1:0] fl);
        int n, err, first;
        logic [DW-1:0] e;
        logic [OUT_W-1:0] o, ex, mk;
        n = (nv > DEPTH) ? DEPTH : nv;
        err = 0;
        first = 0;
        for (int k = 0; k < n; k++) begin
            e  = mem_m[k];
            o  = e[OUT_W-1:0] ^ fl;
            ex = e[IN_W +: OUT_W];
`ifdef MIOC_PATSEQ_MASK_EN
            mk = e[IN_W+OUT_W +: OUT_W];
`else
            mk = '0;
`endif
            if (((o ^ ex) & ~mk) != '0) begin
                if (err == 0) first = k;
                if (err < (1 << CNT_W) - 1) err++;
            end
            cap_q.push_back({s + (k + 1) * HOLD + 1, k[AW-1:0], o});
        end
        res_q.push_back({s + n * HOLD + 1, err[CNT_W-1:0], first[AW-1:0], err == 0});
        run_s = s;
        run_n = n;
        run_end = INF;
        run_live = 1'b1;
    endtask

    // Reset sampled at the end of cycle r: drop anything scheduled later
    task automatic abort_at(input int r);
        logic [CAPW-1:0] tc [$];
        logic [RESW-1:0] tr [$];
        run_end = r;
        foreach (cap_q[i]) if (int'(cap_q[i][CAPW-1 -: 32]) <= r) tc.push_back(cap_q[i]);
        foreach (res_q[i]) if (int'(res_q[i][RESW-1 -: 32]) <= r) tr.push_back(res_q[i]);
        cap_q = tc;
        res_q = tr;
    endtask

    // ---------------- monitor ----------------
    logic [CAPW-1:0] cap_e;
    logic [RESW-1:0] res_e;
    logic done_prev = 1'b0;
    logic start_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("drv", drv, exp_drv_at(cyc));
            check("busy", busy, exp_busy_at(cyc));
            if (cap_valid) begin
                check("cap_pending", 64'(cap_q.size() != 0), 1);
                if (cap_q.size() != 0) begin
                    cap_e = cap_q.pop_front();
                    check("cap_evt", {cyc, cap_idx, cap_data}, cap_e);
                end
            end
            if (done && (!done_prev || start_prev)) begin
                check("done_pending", 64'(res_q.size() != 0), 1);
                if (res_q.size() != 0) begin
                    res_e = res_q.pop_front();
                    check("done_evt", {cyc, err_count, first_err_idx, pass}, res_e);
                end
            end
        end
        done_prev  <= done;
        start_prev <= start;
    end

    // ---------------- driver tasks ----------------
    task automatic load_vec(input int addr, input logic [DW-1:0] d);
        @(posedge clk); #1;
        load_we   = 1'b1;
        load_addr = addr[AW-1:0];
        load_data = d;
        if (!exp_busy_at(cyc)) mem_m[addr] = d;
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    task automatic run_vec(input int nv, input logic [OUT_W-1:0] fl,
                           input int poke_at, input int rst_at);
        int s;
        logic [DW-1:0] junk;
        @(posedge clk); #1;
        flip    = fl;
        num_vec = nv[AW:0];
        start   = 1'b1;
        s = cyc;
        model_run(s, nv, fl);
        for (int i = 1; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (i == poke_at) begin
                // start and load while busy must both be ignored
                junk      = DW'($urandom);
                start     = 1'b1;
                num_vec   = AW'($urandom);
                load_we   = 1'b1;
                load_addr = AW'($urandom_range(0, DEPTH - 1));
                load_data = junk;
                if (!exp_busy_at(cyc)) mem_m[load_addr] = junk;
            end else begin
                start   = 1'b0;
                load_we = 1'b0;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                abort_at(cyc);
            end else begin
                rst_n = 1'b1;
            end
            if (rst_at < 0 && done && i != poke_at) break;
            if (rst_at >= 0 && i > rst_at + 2) break;
        end
        start   = 1'b0;
        load_we = 1'b0;
        rst_n   = 1'b1;
        if (rst_at < 0) check("done_timeout", done, 1);
    endtask

    // ---------------- stimulus ----------------
    logic [IN_W-1:0] st;
    logic [DW-1:0]   rd;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        check("rst_drv", drv, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err_idx, 0);
        check("rst_cap", cap_valid, 0);
        repeat (5) @(posedge clk);

        // Clean loopback run of three vectors
        load_vec(0, {2'b00, 2'b10, 4'b1010});
        load_vec(1, {2'b00, 2'b01, 4'b0101});
        load_vec(2, {2'b00, 2'b00, 4'b1100});
        run_vec(3, 2'b00, -1, -1);
        check("clean_pass", pass, 1);
        check("clean_err", err_count, 0);

        // Corrupt exp[1]; pokes mid-run must be ignored
        load_vec(1, {2'b00, 2'b11, 4'b0101});
        run_vec(3, 2'b00, 3, -1);
        check("mism_err", err_count, 1);
        check("mism_first", first_err_idx, 1);
        check("mism_pass", pass, 0);
        run_vec(3, 2'b00, -1, -1);
        check("mism_again_err", err_count, 1);

        // Empty run
        run_vec(0, 2'b00, -1, -1);
        check("n0_done", done, 1);
        check("n0_pass", pass, 1);

        // Oversized num_vec is clamped to DEPTH
        for (int a = 0; a < DEPTH; a++) load_vec(a, DW'($urandom));
        run_vec(DEPTH + 1, OUT_W'($urandom), -1, -1);

        // Five mismatches saturate a 2-bit counter
        for (int a = 0; a < 5; a++) begin
            st = IN_W'($urandom);
            load_vec(a, {2'b00, ~st[OUT_W-1:0], st});
        end
        run_vec(5, 2'b00, -1, -1);
        check("sat_err", err_count, 3);
        check("sat_first", first_err_idx, 0);
        check("sat_pass", pass, 0);

        // Reset during vector 2, then rerun from vector 0
        run_vec(5, 2'b01, -1, 2 * HOLD + 2);
        check("abort_done", done, 0);
        check("abort_err", err_count, 0);
        check("abort_cap", cap_valid, 0);
        run_vec(5, 2'b01, -1, -1);

        // Masked lane
        load_vec(0, {2'b10, 2'b00, 4'b0010});
        run_vec(1, 2'b00, -1, -1);
`ifdef MIOC_PATSEQ_MASK_EN
        check("mask_err", err_count, 0);
`else
        check("mask_err", err_count, 1);
`endif

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            for (int l = 0; l < $urandom_range(0, 3); l++) begin
                rd = DW'($urandom);
                if ($urandom_range(0, 1) == 1) rd[IN_W +: OUT_W] = rd[OUT_W-1:0];
                load_vec($urandom_range(0, DEPTH - 1), rd);
            end
            run_vec($urandom_range(0, 2 * DEPTH - 1),
                    ($urandom_range(0, 2) == 0) ? OUT_W'($urandom) : 2'b00,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : -1, -1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("cap_q_empty", cap_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mioc_pat_seq.md
Name: mioc_pat_seq

Overview:
- Parametrised on-chip pattern sequencer for MIOC register characterisation.
- Stores stimulus/expected vectors, drives them onto the DUT input lanes, holds each for a fixed number of cycles, samples the DUT outputs and compares them.
- Replaces file-driven bench stimulus with synthesizable BIST logic. Sits between the MIOC test-access interface and the register-under-test lanes.

Parameters:
- IN_W, 4, number of DUT input lanes driven (drv width)
- OUT_W, 2, number of DUT output lanes observed (obs width)
- DEPTH, 16, pattern memory entries (power of two, >=2)
- HOLD, 8, cycles each vector is held before sampling (>=2)
- CNT_W, 8, width of err_count

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- load_we  in  1  pattern memory write strobe; honoured only in IDLE/DONE
- load_addr  in  log2(DEPTH)  write address
- load_data  in  IN_W+2*OUT_W  {mask[OUT_W], exp[OUT_W], stim[IN_W]}
- num_vec  in  log2(DEPTH)+1  vectors to run; sampled on start
- start  in  1  begin run; honoured only in IDLE/DONE
- obs  in  OUT_W  DUT outputs
- drv  out  IN_W  DUT input drive
- busy  out  1  run in progress
- done  out  1  run complete; level, cleared by next start or reset
- pass  out  1  valid while done: 1 = zero mismatches
- err_count  out  CNT_W  mismatch count, saturating
- first_err_idx  out  log2(DEPTH)  index of first mismatching vector
- cap_valid  out  1  one-cycle pulse per sampled vector
- cap_idx  out  log2(DEPTH)  index of captured vector
- cap_data  out  OUT_W  obs value captured

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, index and hold counters 0. Memory contents are not reset. Reset mid-run aborts immediately; drv=0 the next cycle.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE + start=1 (cycle 0):
  - Latch n = min(num_vec, DEPTH); clear err_count, first_err_idx, done, pass.
  - If n=0, go to DONE at cycle 1 with pass=1.
  - Otherwise go to APPLY at cycle 1 with busy=1 and drv=stim[0].
- APPLY: vector k is driven during cycles 1+k*HOLD .. (k+1)*HOLD. The hold counter counts 0..HOLD-1. On the last hold cycle, obs is registered (sample edge) and the FSM moves to CHECK.
- CHECK (single cycle, overlapped):
  - Compare the registered obs against exp[k]; mismatch = |(obs ^ exp).
  - Pulse cap_valid with cap_idx=k and cap_data=registered obs.
  - On mismatch, err_count increments, saturating at 2^CNT_W-1. If this is the first mismatch, first_err_idx=k.
  - Drive of vector k+1 starts in the same cycle, so there is no bubble between vectors. CHECK runs in parallel with APPLY of the next vector.
- Last vector (k=n-1): after its CHECK, go to DONE.
  - done=1, busy=0, drv=0, pass=(err_count==0 including the last compare).
  - For n>=1, done rises at cycle n*HOLD+1, the same cycle as the final cap_valid.
- start while busy is ignored. load_we while busy is ignored; memory is unchanged.
- first_err_idx holds 0 when pass=1.
- Each stim/exp pair is read from a single memory entry, which can be implemented as registers or a synchronous-read array. Read latency must be absorbed so drv timing matches the above.

Optional Feature:
- Macro MIOC_PATSEQ_MASK_EN.
- Defined: the mask field is stored in memory and mismatch = |((obs ^ exp) & ~mask). A mask bit of 1 marks that output lane as don't-care.
- Undefined: mask bits of load_data are ignored and not stored (memory width IN_W+OUT_W); every observed lane is compared.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, release -> drv=0, busy=0, done=0, pass=0, err_count=0, cap_valid never pulses.
- Clean run: HOLD=4, load 3 vectors with stim=4'b1010/4'b0101/4'b1100 and exp equal to a loopback obs; start -> drv=1010 at cycle 1, 0101 at cycle 5, 1100 at cycle 9; cap_valid at cycles 5, 9, 13; done=1 and pass=1 at cycle 13.
- Mismatch: same run with exp[1] corrupted to 2'b11 against obs 2'b01 -> err_count=1, first_err_idx=1, pass=0 at done.
- Boundaries:
  - num_vec=0 -> done=1, pass=1 at cycle 1, no cap_valid.
  - num_vec=DEPTH+1 -> exactly DEPTH cap_valid pulses.
  - CNT_W=2 with 5 mismatches -> err_count=3.
- Reset mid-run: assert rst_n=0 during vector 2 -> next cycle drv=0, busy=0; a subsequent start re-runs from vector 0.
- Mask (MIOC_PATSEQ_MASK_EN defined): exp=2'b00, mask=2'b10, obs=2'b10 -> no mismatch. With the macro undefined, the same stimulus gives err_count=1.
